// File: rtl/user_clock_ctrl.sv
// Overlay user clock generator: free-run, single-step and counted bursts derived from SCLK.
// UCLK is a registered one-cycle-high pulse per tick and is frozen while HOLD is asserted.
module user_clock_ctrl #(
  parameter int          DIV_WIDTH   = 26,
  parameter int unsigned DIV_RESET   = 50000000,
  parameter int          BURST_WIDTH = 16
) (
  input  logic                   i_sclk,
  input  logic                   i_reset,
  input  logic                   i_step,
  input  logic                   i_run_toggle,
  input  logic                   i_hold,
  input  logic                   i_div_load,
  input  logic [DIV_WIDTH-1:0]   i_div_value,
  input  logic                   i_burst_valid,
  input  logic [BURST_WIDTH-1:0] i_burst_count,
  output logic                   o_burst_ready,
  output logic                   o_burst_done,
  output logic                   o_uclk,
  output logic                   o_running,
  output logic [BURST_WIDTH-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST
  } state_t;

  state_t                 r_state;
  logic [DIV_WIDTH-1:0]   r_div;
  logic [DIV_WIDTH-1:0]   r_divcnt;
  logic [BURST_WIDTH-1:0] r_remaining;
  logic [BURST_WIDTH-1:0] r_cycle_count;
  logic                   r_uclk;
  logic                   r_running;
  logic                   r_burst_ready;
  logic                   r_burst_done;
  logic                   r_step_pending;

  logic [DIV_WIDTH-1:0]   w_new_div;
  logic [DIV_WIDTH-1:0]   w_div_eff;
  logic                   w_div_hit;
  logic                   w_div_over;
  logic                   w_tick;
  logic                   w_burst_accept;
  logic                   w_step_req;

  // A freshly loaded divider is compared in the same cycle, so divcnt can never overshoot it.
  assign w_new_div      = (i_div_value == '0) ? DIV_WIDTH'(1) : i_div_value;
  assign w_div_eff      = i_div_load ? w_new_div : r_div;
  assign w_div_hit      = (r_divcnt == w_div_eff);
  assign w_div_over     = (r_divcnt > w_div_eff);
  assign w_tick         = !i_hold && w_div_hit;
  assign w_burst_accept = i_burst_valid && r_burst_ready;
  assign w_step_req     = i_step || r_step_pending;

  // NOTE: all state below is sequential, so every assignment is non-blocking; the
  // defaults at the top of the else-branch make UCLK and BURST_DONE single-cycle pulses.
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_div          <= DIV_WIDTH'(DIV_RESET);
      r_divcnt       <= '0;
      r_remaining    <= '0;
      r_cycle_count  <= '0;
      r_uclk         <= 1'b0;
      r_running      <= 1'b0;
      r_burst_ready  <= 1'b0;
      r_burst_done   <= 1'b0;
      r_step_pending <= 1'b0;
    end else begin
      r_uclk       <= 1'b0;
      r_burst_done <= 1'b0;

      if (i_div_load) r_div <= w_new_div;
      if (r_uclk)     r_cycle_count <= r_cycle_count + BURST_WIDTH'(1);

      case (r_state)
        ST_IDLE: begin
          r_burst_ready <= 1'b1;
          if (w_burst_accept) begin
            r_step_pending <= 1'b0;
            r_divcnt       <= '0;
            if (i_burst_count == '0) begin
              r_burst_done <= 1'b1;
            end else begin
              r_state       <= ST_BURST;
              r_remaining   <= i_burst_count;
              r_burst_ready <= 1'b0;
            end
          end else if (i_run_toggle) begin
            r_state        <= ST_RUN;
            r_running      <= 1'b1;
            r_burst_ready  <= 1'b0;
            r_divcnt       <= '0;
            r_step_pending <= 1'b0;
          end else if (i_hold || r_uclk) begin
            // Held (or just ticked): remember the request so it issues once later.
            r_step_pending <= w_step_req;
          end else begin
            r_uclk         <= w_step_req;
            r_step_pending <= 1'b0;
          end
        end

        ST_RUN: begin
          if (i_run_toggle) begin
            r_state       <= ST_IDLE;
            r_running     <= 1'b0;
            r_burst_ready <= 1'b1;
            r_divcnt      <= '0;
          end else if (w_tick) begin
            r_uclk   <= 1'b1;
            r_divcnt <= '0;
          end else if (!i_hold) begin
            r_divcnt <= r_divcnt + DIV_WIDTH'(1);
          end
        end

        ST_BURST: begin
          if (r_remaining == '0) begin
            r_state       <= ST_IDLE;
            r_burst_done  <= 1'b1;
            r_burst_ready <= 1'b1;
            r_divcnt      <= '0;
          end else if (w_tick) begin
            r_uclk      <= 1'b1;
            r_divcnt    <= '0;
            r_remaining <= r_remaining - BURST_WIDTH'(1);
          end else if (!i_hold) begin
            r_divcnt <= r_divcnt + DIV_WIDTH'(1);
          end
        end

        default: begin
          r_state       <= ST_IDLE;
          r_running     <= 1'b0;
          r_burst_ready <= 1'b1;
          r_divcnt      <= '0;
        end
      endcase

      // A shrinking divider restarts the period instead of letting divcnt run past it.
      if (i_div_load && w_div_over) r_divcnt <= '0;
    end
  end

  assign o_uclk        = r_uclk;
  assign o_running     = r_running;
  assign o_burst_ready = r_burst_ready;
  assign o_burst_done  = r_burst_done;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_user_clock_ctrl.sv
// Directed self-checking bench for user_clock_ctrl: step, run, burst, hold, priority and reset abort.
// Inputs are driven and outputs sampled 1 time unit after each rising SCLK edge.
module tb_user_clock_ctrl;

  localparam int DW = 26;
  localparam int BW = 16;

  logic          clk;
  logic          reset;
  logic          step;
  logic          run_toggle;
  logic          hold;
  logic          div_load;
  logic [DW-1:0] div_value;
  logic          burst_valid;
  logic [BW-1:0] burst_count;
  logic          burst_ready;
  logic          burst_done;
  logic          uclk;
  logic          running;
  logic [BW-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  user_clock_ctrl dut (
    .i_sclk        (clk),
    .i_reset       (reset),
    .i_step        (step),
    .i_run_toggle  (run_toggle),
    .i_hold        (hold),
    .i_div_load    (div_load),
    .i_div_value   (div_value),
    .i_burst_valid (burst_valid),
    .i_burst_count (burst_count),
    .o_burst_ready (burst_ready),
    .o_burst_done  (burst_done),
    .o_uclk        (uclk),
    .o_running     (running),
    .o_cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_div(input logic [DW-1:0] v);
    div_load  = 1'b1;
    div_value = v;
    cyc();
    div_load  = 1'b0;
    div_value = '0;
  endtask

  task automatic pulse_toggle();
    run_toggle = 1'b1;
    cyc();
    run_toggle = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if (uclk !== 1'b0) begin n_fail++; $display("FAIL reset_uclk: got %b want 0", uclk); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    n_checks++;
    if (burst_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", burst_ready); end
    n_checks++;
    if (burst_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", burst_done); end
    n_checks++;
    if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    reset = 1'b0;
    cyc();
    n_checks++;
    if (burst_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", burst_ready); end
  endtask

  task automatic test_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_checks++;
    if (uclk !== 1'b1) begin n_fail++; $display("FAIL step_tick: got %b want 1", uclk); end
    for (int c = 1; c <= 5; c++) begin
      cyc();
      n_checks++;
      if (uclk !== 1'b0) begin n_fail++; $display("FAIL step_single c=%0d: got %b want 0", c, uclk); end
    end
    exp_count += 1;
    n_checks++;
    if (cycle_count !== BW'(exp_count)) begin n_fail++; $display("FAIL step_count: got %0d want %0d", cycle_count, exp_count); end
  endtask

  task automatic test_run();
    int n;
    n = 0;
    load_div(DW'(3));
    pulse_toggle();
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b want 1", running); end
    for (int c = 1; c <= 40; c++) begin
      cyc();
      n_checks++;
      if (uclk !== ((c % 4) == 0)) begin n_fail++; $display("FAIL run_period c=%0d: got %b want %b", c, uclk, (c % 4) == 0); end
      if (uclk === 1'b1) n++;
    end
    n_checks++;
    if (n !== 10) begin n_fail++; $display("FAIL run_ticks: got %0d want 10", n); end
    pulse_toggle();
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL run_stop_running: got %b want 0", running); end
    for (int c = 1; c <= 10; c++) begin
      cyc();
      n_checks++;
      if (uclk !== 1'b0) begin n_fail++; $display("FAIL run_stopped c=%0d: got %b want 0", c, uclk); end
    end
    exp_count += 10;
    n_checks++;
    if (cycle_count !== BW'(exp_count)) begin n_fail++; $display("FAIL run_count: got %0d want %0d", cycle_count, exp_count); end
  endtask

  task automatic test_burst();
    load_div(DW'(1));
    n_checks++;
    if (burst_ready !== 1'b1) begin n_fail++; $display("FAIL burst_pre_ready: got %b want 1", burst_ready); end
    burst_valid = 1'b1;
    burst_count = BW'(5);
    cyc();
    burst_valid = 1'b0;
    burst_count = '0;
    n_checks++;
    if (burst_ready !== 1'b0) begin n_fail++; $display("FAIL burst_busy_ready: got %b want 0", burst_ready); end
    for (int c = 1; c <= 14; c++) begin
      cyc();
      n_checks++;
      if (uclk !== ((c <= 10) && (c % 2 == 0))) begin n_fail++; $display("FAIL burst_tick c=%0d: got %b", c, uclk); end
      n_checks++;
      if (burst_done !== (c == 11)) begin n_fail++; $display("FAIL burst_done c=%0d: got %b want %b", c, burst_done, c == 11); end
      if (c == 11) begin
        n_checks++;
        if (burst_ready !== 1'b1) begin n_fail++; $display("FAIL burst_end_ready: got %b want 1", burst_ready); end
      end
    end
    exp_count += 5;
    n_checks++;
    if (cycle_count !== BW'(exp_count)) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", cycle_count, exp_count); end
  endtask

  task automatic test_burst_zero();
    burst_valid = 1'b1;
    burst_count = '0;
    cyc();
    burst_valid = 1'b0;
    n_checks++;
    if (burst_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", burst_done); end
    n_checks++;
    if (burst_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", burst_ready); end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_checks++;
      if (uclk !== 1'b0 || burst_done !== 1'b0) begin n_fail++; $display("FAIL zero_quiet c=%0d: uclk %b done %b want 0 0", c, uclk, burst_done); end
    end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL zero_running: got %b want 0", running); end
  endtask

  task automatic test_hold_run();
    load_div(DW'(3));
    pulse_toggle();
    cyc();
    cyc();
    hold = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      n_checks++;
      if (uclk !== 1'b0) begin n_fail++; $display("FAIL hold_frozen c=%0d: got %b want 0", c, uclk); end
    end
    hold = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      n_checks++;
      if (uclk !== (c == 2 || c == 6)) begin n_fail++; $display("FAIL hold_resume c=%0d: got %b want %b", c, uclk, c == 2 || c == 6); end
    end
    pulse_toggle();
    exp_count += 2;
    n_checks++;
    if (cycle_count !== BW'(exp_count)) begin n_fail++; $display("FAIL hold_run_count: got %0d want %0d", cycle_count, exp_count); end
  endtask

  task automatic test_hold_step();
    hold = 1'b1;
    cyc();
    repeat (3) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc();
      n_checks++;
      if (uclk !== 1'b0) begin n_fail++; $display("FAIL held_step: got %b want 0", uclk); end
    end
    hold = 1'b0;
    cyc();
    n_checks++;
    if (uclk !== 1'b1) begin n_fail++; $display("FAIL pending_step: got %b want 1", uclk); end
    for (int c = 1; c <= 5; c++) begin
      cyc();
      n_checks++;
      if (uclk !== 1'b0) begin n_fail++; $display("FAIL pending_collapse c=%0d: got %b want 0", c, uclk); end
    end
    exp_count += 1;
    n_checks++;
    if (cycle_count !== BW'(exp_count)) begin n_fail++; $display("FAIL hold_step_count: got %0d want %0d", cycle_count, exp_count); end
  endtask

  task automatic test_priority();
    step = 1'b1;
    run_toggle = 1'b1;
    cyc();
    step = 1'b0;
    run_toggle = 1'b0;
    n_checks++;
    if (running !== 1'b1 || uclk !== 1'b0) begin n_fail++; $display("FAIL prio_toggle: running %b uclk %b want 1 0", running, uclk); end
    cyc();
    n_checks++;
    if (uclk !== 1'b0) begin n_fail++; $display("FAIL prio_step_dropped: got %b want 0", uclk); end
    pulse_toggle();
    burst_valid = 1'b1;
    burst_count = BW'(2);
    run_toggle  = 1'b1;
    step        = 1'b1;
    cyc();
    burst_valid = 1'b0;
    burst_count = '0;
    run_toggle  = 1'b0;
    step        = 1'b0;
    n_checks++;
    if (running !== 1'b0 || burst_ready !== 1'b0 || uclk !== 1'b0) begin
      n_fail++; $display("FAIL prio_burst: running %b ready %b uclk %b want 0 0 0", running, burst_ready, uclk);
    end
    for (int c = 1; c <= 10; c++) begin
      cyc();
      n_checks++;
      if (uclk !== (c == 4 || c == 8) || burst_done !== (c == 9)) begin
        n_fail++; $display("FAIL prio_burst_seq c=%0d: uclk %b done %b", c, uclk, burst_done);
      end
    end
    exp_count += 2;
  endtask

  task automatic test_div_zero();
    load_div('0);
    pulse_toggle();
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_checks++;
      if (uclk !== (c % 2 == 0)) begin n_fail++; $display("FAIL div0_period c=%0d: got %b want %b", c, uclk, c % 2 == 0); end
    end
    pulse_toggle();
    exp_count += 2;
    n_checks++;
    if (cycle_count !== BW'(exp_count)) begin n_fail++; $display("FAIL div0_count: got %0d want %0d", cycle_count, exp_count); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    n = 0;
    load_div(DW'(1));
    burst_valid = 1'b1;
    burst_count = BW'(100);
    cyc();
    burst_valid = 1'b0;
    burst_count = '0;
    for (int c = 1; c <= 80; c++) begin
      cyc();
      if (uclk === 1'b1) n++;
    end
    n_checks++;
    if (n !== 40 || uclk !== 1'b1) begin n_fail++; $display("FAIL abort_pre_ticks: got %0d uclk %b want 40 1", n, uclk); end
    reset = 1'b1;
    cyc();
    n_checks++;
    if (uclk !== 1'b0 || cycle_count !== 16'd0 || burst_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset: uclk %b count %0d done %b want 0 0 0", uclk, cycle_count, burst_done);
    end
    reset = 1'b0;
    exp_count = 0;
    cyc();
    n_checks++;
    if (burst_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", burst_ready); end
    for (int c = 1; c <= 10; c++) begin
      cyc();
      n_checks++;
      if (uclk !== 1'b0 || burst_done !== 1'b0 || running !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet c=%0d: uclk %b done %b running %b", c, uclk, burst_done, running);
      end
    end
    n_checks++;
    if (cycle_count !== BW'(exp_count)) begin n_fail++; $display("FAIL abort_count: got %0d want %0d", cycle_count, exp_count); end
  endtask

  initial begin
    reset       = 1'b1;
    step        = 1'b0;
    run_toggle  = 1'b0;
    hold        = 1'b0;
    div_load    = 1'b0;
    div_value   = '0;
    burst_valid = 1'b0;
    burst_count = '0;
    test_reset();
    test_step();
    test_run();
    test_burst();
    test_burst_zero();
    test_hold_run();
    test_hold_step();
    test_priority();
    test_div_zero();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
